// File: rtl/adpll_gain_sweep_if.sv
// rtl/adpll_gain_sweep_if.sv - per-point result stream between the gain sweeper and its consumer
interface adpll_gain_sweep_if #(
    parameter int KP_WIDTH   = 5,
    parameter int KI_WIDTH   = 8,
    parameter int TIME_WIDTH = 20
);
    logic                  result_valid_o;
    logic                  result_ready_i;
    logic [KP_WIDTH-1:0]   result_kp_o;
    logic [KI_WIDTH-1:0]   result_ki_o;
    logic [TIME_WIDTH-1:0] result_time_o;
    logic                  result_timeout_o;

    modport master (
        output result_valid_o,
        output result_kp_o,
        output result_ki_o,
        output result_time_o,
        output result_timeout_o,
        input  result_ready_i
    );

    modport slave (
        input  result_valid_o,
        input  result_kp_o,
        input  result_ki_o,
        input  result_time_o,
        input  result_timeout_o,
        output result_ready_i
    );
endinterface

// File: rtl/adpll_gain_sweep.sv
// rtl/adpll_gain_sweep.sv - sweeps ADPLL Kp/Ki grid, measures lock time per point, tracks the fastest
module adpll_gain_sweep #(
    parameter int KP_WIDTH       = 5,
    parameter int KI_WIDTH       = 8,
    parameter int ERR_WIDTH      = 8,
    parameter int TIME_WIDTH     = 20,
    parameter int LOCK_THRESH    = 2,
    parameter int LOCK_HOLD      = 16,
    parameter int DISABLE_CYCLES = 64
) (
    input  logic                  fpga_clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [KP_WIDTH-1:0]   kp_max_i,
    input  logic [KI_WIDTH-1:0]   ki_max_i,
    input  logic [ERR_WIDTH-1:0]  error_i,
    input  logic                  error_valid_i,
    output logic                  pll_enable_o,
    output logic [KP_WIDTH-1:0]   kp_o,
    output logic [KI_WIDTH-1:0]   ki_o,
    adpll_gain_sweep_if.master    res_if,
    output logic                  best_valid_o,
    output logic [KP_WIDTH-1:0]   best_kp_o,
    output logic [KI_WIDTH-1:0]   best_ki_o,
    output logic [TIME_WIDTH-1:0] best_time_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DISABLE = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_REPORT  = 3'd3;
    localparam logic [2:0] S_NEXT    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int DIS_W  = $clog2(DISABLE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LOCK_HOLD + 1);
    localparam logic [DIS_W-1:0]      DIS_LAST   = DIS_W'(DISABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]     HOLD_LAST  = HOLD_W'(LOCK_HOLD - 1);
    localparam logic [ERR_WIDTH:0]    THRESH     = (ERR_WIDTH + 1)'(LOCK_THRESH);
    localparam logic [TIME_WIDTH-1:0] TIME_ONES  = {TIME_WIDTH{1'b1}};

    logic [2:0]            state_q, state_d;
    logic [KP_WIDTH-1:0]   kp_q, kp_d;
    logic [KI_WIDTH-1:0]   ki_q, ki_d;
    logic [DIS_W-1:0]      dis_cnt_q, dis_cnt_d;
    logic [TIME_WIDTH-1:0] time_cnt_q, time_cnt_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [KP_WIDTH-1:0]   res_kp_q, res_kp_d;
    logic [KI_WIDTH-1:0]   res_ki_q, res_ki_d;
    logic [TIME_WIDTH-1:0] res_time_q, res_time_d;
    logic                  res_to_q, res_to_d;
    logic                  best_valid_q, best_valid_d;
    logic [KP_WIDTH-1:0]   best_kp_q, best_kp_d;
    logic [KI_WIDTH-1:0]   best_ki_q, best_ki_d;
    logic [TIME_WIDTH-1:0] best_time_q, best_time_d;

    // One extra bit so that the most-negative error has magnitude 2^(ERR_WIDTH-1) and never qualifies.
    logic [ERR_WIDTH:0] err_ext;
    logic [ERR_WIDTH:0] err_abs;
    logic               err_ok;
    logic               lock_hit;

    always_comb begin
        err_ext  = {error_i[ERR_WIDTH-1], error_i};
        err_abs  = err_ext[ERR_WIDTH] ? (~err_ext + 1'b1) : err_ext;
        err_ok   = (err_abs <= THRESH);
        lock_hit = error_valid_i && err_ok && (hold_cnt_q == HOLD_LAST);
    end

    always_comb begin
        state_d      = state_q;
        kp_d         = kp_q;
        ki_d         = ki_q;
        dis_cnt_d    = dis_cnt_q;
        time_cnt_d   = time_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        res_kp_d     = res_kp_q;
        res_ki_d     = res_ki_q;
        res_time_d   = res_time_q;
        res_to_d     = res_to_q;
        best_valid_d = best_valid_q;
        best_kp_d    = best_kp_q;
        best_ki_d    = best_ki_q;
        best_time_d  = best_time_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    kp_d         = '0;
                    ki_d         = '0;
                    best_valid_d = 1'b0;
                    best_time_d  = TIME_ONES;
                    dis_cnt_d    = '0;
                    state_d      = S_DISABLE;
                end
            end
            S_DISABLE: begin
                if (dis_cnt_q == DIS_LAST) begin
                    time_cnt_d = '0;
                    hold_cnt_d = '0;
                    state_d    = S_RUN;
                end else begin
                    dis_cnt_d = dis_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                time_cnt_d = time_cnt_q + 1'b1;
                if (error_valid_i) begin
                    hold_cnt_d = err_ok ? hold_cnt_q + 1'b1 : '0;
                end
                res_kp_d = kp_q;
                res_ki_d = ki_q;
                // Lock is checked first so a lock on the final counted cycle is not reported as a timeout.
                if (lock_hit) begin
                    res_time_d = time_cnt_q;
                    res_to_d   = 1'b0;
                    state_d    = S_REPORT;
                end else if (time_cnt_q == TIME_ONES) begin
                    res_time_d = TIME_ONES;
                    res_to_d   = 1'b1;
                    state_d    = S_REPORT;
                end
            end
            S_REPORT: begin
                if (res_if.result_ready_i) begin
                    if (!res_to_q && (res_time_q < best_time_q)) begin
                        best_valid_d = 1'b1;
                        best_kp_d    = res_kp_q;
                        best_ki_d    = res_ki_q;
                        best_time_d  = res_time_q;
                    end
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                dis_cnt_d = '0;
                if (ki_q == ki_max_i) begin
                    ki_d = '0;
                    if (kp_q == kp_max_i) begin
                        state_d = S_DONE;
                    end else begin
                        kp_d    = kp_q + 1'b1;
                        state_d = S_DISABLE;
                    end
                end else begin
                    ki_d    = ki_q + 1'b1;
                    state_d = S_DISABLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            kp_q         <= '0;
            ki_q         <= '0;
            dis_cnt_q    <= '0;
            time_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            res_kp_q     <= '0;
            res_ki_q     <= '0;
            res_time_q   <= '0;
            res_to_q     <= 1'b0;
            best_valid_q <= 1'b0;
            best_kp_q    <= '0;
            best_ki_q    <= '0;
            best_time_q  <= '0;
        end else begin
            state_q      <= state_d;
            kp_q         <= kp_d;
            ki_q         <= ki_d;
            dis_cnt_q    <= dis_cnt_d;
            time_cnt_q   <= time_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            res_kp_q     <= res_kp_d;
            res_ki_q     <= res_ki_d;
            res_time_q   <= res_time_d;
            res_to_q     <= res_to_d;
            best_valid_q <= best_valid_d;
            best_kp_q    <= best_kp_d;
            best_ki_q    <= best_ki_d;
            best_time_q  <= best_time_d;
        end
    end

    assign pll_enable_o            = (state_q == S_RUN) || (state_q == S_REPORT);
    assign busy_o                  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o                  = (state_q == S_DONE);
    assign kp_o                    = kp_q;
    assign ki_o                    = ki_q;
    assign res_if.result_valid_o   = (state_q == S_REPORT);
    assign res_if.result_kp_o      = res_kp_q;
    assign res_if.result_ki_o      = res_ki_q;
    assign res_if.result_time_o    = res_time_q;
    assign res_if.result_timeout_o = res_to_q;
    assign best_valid_o            = best_valid_q;
    assign best_kp_o               = best_kp_q;
    assign best_ki_o               = best_ki_q;
    assign best_time_o             = best_time_q;
endmodule

// File: doc/adpll_gain_sweep.md
Name: adpll_gain_sweep

Overview:
- Automated successor to the manual switch-driven Kp/Ki gain test.
- Steps the ADPLL through every (Kp, Ki) pair in a runtime-bounded grid. For each pair it disables the loop, re-enables it and measures the fpga_clk_i cycles to a confirmed lock.
- Streams one result per pair over a valid/ready handshake and tracks the fastest-locking pair.
- Sits between the ADPLL (drives its enable_i, kp_i, ki_i; reads its error_o) and the display/UART reporting logic.

Parameters:
KP_WIDTH, 5, width of kp_o and kp_max_i
KI_WIDTH, 8, width of ki_o and ki_max_i
ERR_WIDTH, 8, width of signed error_i
TIME_WIDTH, 20, width of the lock-time counter; timeout = 2^TIME_WIDTH-1 cycles
LOCK_THRESH, 2, lock criterion on the error: |error| <= LOCK_THRESH
LOCK_HOLD, 16, number of consecutive qualifying error samples that confirm lock
DISABLE_CYCLES, 64, cycles pll_enable_o is held low before each measurement

Ports:
fpga_clk_i  in  1  system clock (258 MHz domain)
reset_i  in  1  synchronous, active-high reset
start_i  in  1  begin sweep; sampled in IDLE and DONE only
kp_max_i  in  KP_WIDTH  last Kp value in the sweep (inclusive)
ki_max_i  in  KI_WIDTH  last Ki value in the sweep (inclusive)
error_i  in  ERR_WIDTH  signed ADPLL phase error
error_valid_i  in  1  one-cycle strobe: error_i holds a new sample
pll_enable_o  out  1  ADPLL enable
kp_o  out  KP_WIDTH  current Kp to the ADPLL
ki_o  out  KI_WIDTH  current Ki to the ADPLL
result_valid_o  out  1  result fields valid
result_ready_i  in  1  consumer accepts the result
result_kp_o  out  KP_WIDTH  Kp of the reported point
result_ki_o  out  KI_WIDTH  Ki of the reported point
result_time_o  out  TIME_WIDTH  lock time in cycles; all-ones on timeout
result_timeout_o  out  1  the point failed to lock
best_valid_o  out  1  at least one point has locked this sweep
best_kp_o  out  KP_WIDTH  Kp of the fastest lock
best_ki_o  out  KI_WIDTH  Ki of the fastest lock
best_time_o  out  TIME_WIDTH  fastest lock time
busy_o  out  1  sweep in progress
done_o  out  1  sweep complete

Behaviour:
- Clock and reset: one clock, fpga_clk_i. reset_i is synchronous, active-high and dominates in any state.
- Reset values: state goes to IDLE, every output is 0, and internal counters are cleared.
- States: IDLE, DISABLE, RUN, REPORT, NEXT, DONE.
- IDLE:
  - busy_o=0, pll_enable_o=0.
  - On start_i: kp=0, ki=0, best_valid_o=0, best_time_o=all-ones, go to DISABLE.
- DISABLE:
  - pll_enable_o=0 and busy_o=1 for exactly DISABLE_CYCLES cycles, then go to RUN.
  - On entry to RUN, time_cnt and hold_cnt are cleared.
- RUN:
  - pll_enable_o=1. time_cnt increments every cycle.
  - On each error_valid_i: if |error_i| <= LOCK_THRESH, hold_cnt++; otherwise hold_cnt=0.
  - |error_i| is computed in ERR_WIDTH+1 bits, so the most-negative value never qualifies.
  - When hold_cnt reaches LOCK_HOLD: capture result_time=time_cnt and timeout=0, then go to REPORT.
  - If time_cnt reaches all-ones first: capture result_time=all-ones and timeout=1, then go to REPORT.
  - If both occur in the same cycle, the lock wins.
  - error_valid_i outside RUN is ignored.
- REPORT:
  - result_valid_o=1 and pll_enable_o=1. All result_* outputs are stable until the handshake.
  - The handshake is result_valid_o & result_ready_i. Ready may be held high permanently, giving a one-cycle valid.
  - On the handshake cycle: if !timeout and result_time < best_time_o, update the best_* outputs and set best_valid_o=1. Ties keep the earlier point.
  - Then go to NEXT; result_valid_o drops in the next cycle.
- NEXT (one cycle):
  - If ki==ki_max_i: ki=0, then DONE if kp==kp_max_i, else kp++ and go to DISABLE.
  - Otherwise ki++ and go to DISABLE.
  - kp_o and ki_o change only here or on start.
- DONE:
  - done_o=1, busy_o=0, pll_enable_o=0. The best_* outputs hold their values.
  - On start_i a new sweep begins, exactly as from IDLE.
- Input sampling: kp_max_i and ki_max_i are sampled continuously. A change mid-sweep takes effect at the next NEXT.
- Zero bounds: kp_max_i=0 with ki_max_i=0 gives a single-point sweep.
- Cycle count per point: DISABLE_CYCLES + lock time + handshake wait + 1.

Test Plan:
- Reset then start: kp_max=0, ki_max=0; error_valid every 4 cycles with error=1. Required: lock confirmed on the 16th sample; exactly one result with kp=0, ki=0, timeout=0; best_valid=1; done_o asserts.
- Grid order: kp_max=1, ki_max=2. Required: 6 results in the order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); pll_enable_o low for 64 cycles before each RUN.
- Timeout: TIME_WIDTH=8, error=50 constantly. Required: result_time=255, result_timeout=1, best_valid stays 0.
- Hold reset: 15 samples with error=2, then one with error=3, then 16 with error=-2. Required: lock is confirmed only on the final sample. Also error=-128 never counts as qualifying.
- Backpressure and best tracking: result_ready held low for 100 cycles. Required: result fields stable and no advance; after ready, the best updates only on a strictly smaller lock time.
- reset_i mid-RUN: all outputs return to 0 on the next edge; start_i restarts the sweep at (0,0).
